// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU-sharing arbiter: ALU opcodes, arbiter state
// encoding and requester index names.
package alu_share_arbiter_pkg;

   localparam int ALU_OP_LENGTH = 4;

   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD  = 4'd0;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB  = 4'd1;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLL  = 4'd2;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLT  = 4'd3;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLTU = 4'd4;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_XOR  = 4'd5;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRL  = 4'd6;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRA  = 4'd7;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR   = 4'd8;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND  = 4'd9;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   localparam logic ARB_REQ_EXU = 1'b0;
   localparam logic ARB_REQ_BRU = 1'b1;

endpackage

// File: rtl/alu.sv
// Core combinational ALU. Unknown opcodes fall back to add; Zero flags an
// all-zero result.
module alu
   import alu_share_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]    src_a,
   input  logic [DATA_WIDTH-1:0]    src_b,
   input  logic [ALU_OP_LENGTH-1:0] alu_op,
   output logic [DATA_WIDTH-1:0]    result,
   output logic                     zero
);

   localparam int SHW = $clog2(DATA_WIDTH);

   logic [SHW-1:0] shamt;
   assign shamt = src_b[SHW-1:0];

   always_comb begin
      result = src_a + src_b;
      case (alu_op)
         ALU_OP_SUB:  result = src_a - src_b;
         ALU_OP_SLL:  result = src_a << shamt;
         ALU_OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
         ALU_OP_XOR:  result = src_a ^ src_b;
         ALU_OP_SRL:  result = src_a >> shamt;
         ALU_OP_SRA:  result = $unsigned($signed(src_a) >>> shamt);
         ALU_OP_OR:   result = src_a | src_b;
         ALU_OP_AND:  result = src_a & src_b;
         default:     result = src_a + src_b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone valid requester always wins, a tie is
// broken by ptr. Nothing is granted while en is low.
module alu_rr_pick
   import alu_share_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       ptr,
   input  logic       en,
   output logic       grant,
   output logic       grant_valid
);

   assign grant_valid = en & (|valid);
   assign grant       = (&valid) ? ptr : valid[ARB_REQ_BRU];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EXU and BRU requesters with
// round-robin grants and a single registered response slot.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = ALU_OP_LENGTH,
   parameter int TAG_WIDTH  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*DATA_WIDTH-1:0] req_a,
   input  logic [2*DATA_WIDTH-1:0] req_b,
   input  logic [2*OP_WIDTH-1:0]   req_op,
   input  logic [2*TAG_WIDTH-1:0]  req_tag,
   output logic [1:0]              resp_valid,
   input  logic [1:0]              resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_result,
   output logic                    resp_zero,
   output logic [TAG_WIDTH-1:0]    resp_tag,
   output logic [CNT_WIDTH-1:0]    grant_cnt0,
   output logic [CNT_WIDTH-1:0]    grant_cnt1
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   arb_state_e            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

   logic                  free;
   logic                  grant;
   logic                  grant_valid;
   logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [OP_WIDTH-1:0]   alu_op;
   logic [TAG_WIDTH-1:0]  win_tag;
   logic                  alu_zero;

   // Only the owner's resp_ready can free the slot; the other bit is ignored.
   assign free = (state_q == ARB_IDLE) | ((state_q == ARB_HOLD) & resp_ready[owner_q]);

   alu_rr_pick u_pick (
      .valid       (req_valid),
      .ptr         (rr_ptr_q),
      .en          (free),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign alu_a   = grant ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
   assign alu_b   = grant ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
   assign alu_op  = grant ? req_op[2*OP_WIDTH-1:OP_WIDTH]    : req_op[OP_WIDTH-1:0];
   assign win_tag = grant ? req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : req_tag[TAG_WIDTH-1:0];

   alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .src_a  (alu_a),
      .src_b  (alu_b),
      .alu_op (alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         owner_q  <= ARB_REQ_EXU;
         rr_ptr_q <= ARB_REQ_EXU;
         result_q <= '0;
         zero_q   <= 1'b0;
         tag_q    <= '0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         tag_q    <= tag_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      result_d = result_q;
      zero_d   = zero_q;
      tag_d    = tag_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;
      if (grant_valid) begin
         state_d  = ARB_HOLD;
         owner_d  = grant;
         rr_ptr_d = ~grant;
         result_d = alu_result;
         zero_d   = alu_zero;
         tag_d    = win_tag;
         if (grant == ARB_REQ_EXU) cnt0_d = sat_inc(cnt0_q);
         else                      cnt1_d = sat_inc(cnt1_q);
      end else if ((state_q == ARB_HOLD) && resp_ready[owner_q]) begin
         state_d = ARB_IDLE;
      end
   end

   always_comb begin
      resp_valid = 2'b00;
      if (state_q == ARB_HOLD) begin
         resp_valid[ARB_REQ_EXU] = (owner_q == ARB_REQ_EXU);
         resp_valid[ARB_REQ_BRU] = (owner_q == ARB_REQ_BRU);
      end
      req_ready              = 2'b00;
      req_ready[ARB_REQ_EXU] = grant_valid & (grant == ARB_REQ_EXU);
      req_ready[ARB_REQ_BRU] = grant_valid & (grant == ARB_REQ_BRU);
   end

   assign resp_result = result_q;
   assign resp_zero   = zero_q;
   assign resp_tag    = tag_q;
   assign grant_cnt0  = cnt0_q;
   assign grant_cnt1  = cnt1_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the core's combinational ALU between two requesters: requester 0 is the EXU integer path, requester 1 is the branch/address-generation path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. The ALU result is registered, so a response appears one cycle after acceptance. Throughput is one operation per cycle while responses are consumed promptly.
- Per-requester grant counters are provided for performance monitoring.

Parameters:
DATA_WIDTH, 32, operand/result width passed to the ALU
OP_WIDTH, 4, ALU opcode width (equals the shared ALU_OP_LENGTH constant)
TAG_WIDTH, 4, opaque requester tag returned with the result
CNT_WIDTH, 16, width of the saturating grant counters

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester request accepted this cycle when valid&ready
req_a  in  2*DATA_WIDTH  SrcA per requester, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  2*DATA_WIDTH  SrcB per requester, same packing
req_op  in  2*OP_WIDTH  ALU opcode per requester
req_tag  in  2*TAG_WIDTH  tag per requester
resp_valid  out  2  result valid for requester i
resp_ready  in  2  requester i consumes result
resp_result  out  DATA_WIDTH  registered ALU result, shared bus, qualified by resp_valid
resp_zero  out  1  registered ALU Zero flag
resp_tag  out  TAG_WIDTH  tag of the accepted request
grant_cnt0  out  CNT_WIDTH  saturating count of accepted requests from requester 0
grant_cnt1  out  CNT_WIDTH  saturating count of accepted requests from requester 1

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, owner=0, rr_ptr=0 (requester 0 preferred).
  - resp_valid=0, resp_result=0, resp_zero=0, resp_tag=0.
  - grant_cnt0=grant_cnt1=0, req_ready=0.
  - An in-flight result is discarded. No response is produced for it after reset release.
- States:
  - IDLE: no result held.
  - HOLD: result register valid, owner=k. resp_valid = onehot(owner) in HOLD only.
- Slot free condition: free = (state==IDLE) | (state==HOLD & resp_ready[owner]).
- Grant: computed combinationally when free.
  - Only one requester valid: that requester wins.
  - Both valid: requester rr_ptr wins.
  - req_ready[g] = free & grant==g. The loser sees req_ready=0.
- Accept cycle (valid&ready):
  - ALU is fed the winner's a/b/op.
  - Result, Zero and tag are registered. owner<=g, state<=HOLD, rr_ptr<=~g.
- Latency: accept in cycle N, resp_valid visible in cycle N+1. Back-to-back acceptance is allowed in the same cycle as the response handshake.
- HOLD with resp_ready[owner]=1 and no request valid: state<=IDLE.
- HOLD with resp_ready[owner]=0: result, Zero and tag held stable, and no request is accepted. Backpressure stalls both requesters.
- resp_ready of the non-owner is ignored.
- Requester obligation: once req_valid[i] is high it stays high with stable payload until accepted. The bench asserts this. The arbiter never retracts a grant.
- rr_ptr changes only on acceptance. Idle cycles do not alter priority.
- Counters: +1 on each accept of that requester, saturating at all-ones (no wrap).
- Arithmetic, including width and signedness rules, is entirely the ALU's. The arbiter adds no transformation.
- Unknown opcode: passed through unchanged, so the ALU default (add) applies.
- Owner is the only response-path selector. resp_tag echoes the tag of the accepted request.

Decomposition:
- Shared package/header holds:
  - ALU opcode constants (ALU_OP_ADD, ALU_OP_SUB, ... ALU_OP_SRA) and ALU_OP_LENGTH.
  - State encoding (ARB_IDLE, ARB_HOLD).
  - Requester index names (ARB_REQ_EXU=0, ARB_REQ_BRU=1).
- Sub-module: alu_rr_pick, a 2-way round-robin picker with inputs valid[1:0], ptr, en and outputs grant index and grant_valid.
- The ALU is instantiated directly, not re-implemented.

Test Plan:
- Reset value check: hold rstn low, then release. All outputs are 0, including resp_valid=00 and grant_cnt=0.
- Single request, ADD: r0 issues a=5, b=7, op=ADD, tag=3 in cycle 1.
  - req_ready[0]=1 in cycle 1.
  - resp_valid=01 in cycle 2, result=12, zero=0, tag=3.
  - grant_cnt0=1.
- Simultaneous requests after reset:
  - r0 issues SUB 9-9 (tag 1) and r1 issues SLTU 1<2 (tag 2).
  - r0 is granted first: result=0, zero=1.
  - r1 is accepted in the r0 response-handshake cycle and gets result=1 next cycle.
  - rr_ptr then points to r0.
- Backpressure: r1 result pending with resp_ready[1]=0 for 4 cycles while r0 valid.
  - req_ready=00 throughout.
  - resp_result stays stable.
  - On the cycle resp_ready[1]=1, r0 is accepted.
- Fairness: both requesters continuously valid with resp_ready=11 for 10 accepts. Grants alternate 0,1,0,1..., and grant_cnt0=grant_cnt1=5.
- Reset mid-operation: assert rstn low while in HOLD. resp_valid drops asynchronously, and no stale response appears after release. Separately, force grant_cnt0 to all-ones and accept one more r0 request; it stays all-ones.
